// File: rtl/i2c_tx_fifo_pkg.sv
// Shared I2C constants: status-byte bit positions and almost-empty/full thresholds
// used by the transmit FIFO.
package i2c_tx_fifo_pkg;

  localparam int STATUS_WIDTH  = 8;

  localparam int EMPTY_BIT     = 0;
  localparam int FULL_BIT      = 1;
  localparam int AEMPTY_BIT    = 2;
  localparam int AFULL_BIT     = 3;
  localparam int OVERFLOW_BIT  = 4;
  localparam int UNDERFLOW_BIT = 5;

  // almost_empty when count <= AEMPTY_OFFSET, almost_full when count >= DEPTH - AFULL_OFFSET
  localparam int AEMPTY_OFFSET = 1;
  localparam int AFULL_OFFSET  = 2;

endpackage

// File: rtl/i2c_fifo_ram.sv
// Simple dual-port storage for the I2C TX FIFO: one write port and one registered,
// read-first read port. No reset so it maps onto block RAM.
module i2c_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  pclk_i,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  always_ff @(posedge pclk_i) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Read-first: a same-address write in the same cycle returns the old word,
  // which is what a full FIFO doing write+pop needs.
  always_ff @(posedge pclk_i) begin
    if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/i2c_tx_fifo.sv
// I2C transmit FIFO with occupancy count and APB status byte.
// Define I2C_TX_FIFO_ERR_FLAG_EN to build sticky overflow/underflow flags.
module i2c_tx_fifo
  import i2c_tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    pclk_i,
  input  logic                    preset_i,
  input  logic                    flush_i,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_en_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    rd_valid_o,
  output logic [ADDR_WIDTH:0]     count_o,
  output logic [STATUS_WIDTH-1:0] status_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] AEMPTY_LVL = CW'(AEMPTY_OFFSET);
  localparam logic [CW-1:0] AFULL_LVL  = CW'(DEPTH - AFULL_OFFSET);

  logic [ADDR_WIDTH-1:0] wptr_reg, wptr_next;
  logic [ADDR_WIDTH-1:0] rptr_reg, rptr_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  rd_valid_reg;
  logic                  data_clr_reg;
  logic                  empty, full;
  logic                  pop_ok, wr_ok;
  logic                  ovf_flag, udf_flag;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_LVL);

  // A pop on a full FIFO frees the slot the write lands in during the same cycle.
  assign pop_ok = rd_en_i & ~empty & ~flush_i & ~preset_i;
  assign wr_ok  = wr_en_i & (~full | pop_ok) & ~flush_i & ~preset_i;

  always_comb begin
    wptr_next  = wptr_reg + ADDR_WIDTH'(wr_ok);
    rptr_next  = rptr_reg + ADDR_WIDTH'(pop_ok);
    count_next = count_reg + CW'(wr_ok) - CW'(pop_ok);
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      count_reg    <= '0;
      rd_valid_reg <= 1'b0;
      data_clr_reg <= 1'b1;
    end else if (flush_i) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      count_reg    <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      wptr_reg     <= wptr_next;
      rptr_reg     <= rptr_next;
      count_reg    <= count_next;
      rd_valid_reg <= pop_ok;
      if (pop_ok) begin
        data_clr_reg <= 1'b0;
      end
    end
  end

`ifdef I2C_TX_FIFO_ERR_FLAG_EN
  logic ovf_reg, udf_reg;

  always_ff @(posedge pclk_i) begin
    if (preset_i || flush_i) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      if (wr_en_i && full && !rd_en_i) begin
        ovf_reg <= 1'b1;
      end
      if (rd_en_i && empty) begin
        udf_reg <= 1'b1;
      end
    end
  end

  assign ovf_flag = ovf_reg;
  assign udf_flag = udf_reg;
`else
  assign ovf_flag = 1'b0;
  assign udf_flag = 1'b0;
`endif

  i2c_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .pclk_i  (pclk_i),
    .wr_en   (wr_ok),
    .wr_addr (wptr_reg),
    .wr_data (wr_data_i),
    .rd_en   (pop_ok),
    .rd_addr (rptr_reg),
    .rd_data (ram_rd_data)
  );

  // The RAM output register has no reset, so mask it until the first real pop.
  assign rd_data_o  = data_clr_reg ? '0 : ram_rd_data;
  assign rd_valid_o = rd_valid_reg;
  assign count_o    = count_reg;

  always_comb begin
    status_o                = '0;
    status_o[EMPTY_BIT]     = empty;
    status_o[FULL_BIT]      = full;
    status_o[AEMPTY_BIT]    = (count_reg <= AEMPTY_LVL);
    status_o[AFULL_BIT]     = (count_reg >= AFULL_LVL);
    status_o[OVERFLOW_BIT]  = ovf_flag;
    status_o[UNDERFLOW_BIT] = udf_flag;
  end

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Bench for i2c_tx_fifo: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model.
module tb_i2c_tx_fifo;

  logic       pclk_i;
  logic       preset_i;
  logic       flush_i;
  logic       wr_en_i;
  logic [7:0] wr_data_i;
  logic       rd_en_i;
  logic [7:0] rd_data_o;
  logic       rd_valid_o;
  logic [4:0] count_o;
  logic [7:0] status_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] model_q[$];
  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_ovf;
  logic       exp_udf;

  i2c_tx_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4)
  ) dut (
    .pclk_i     (pclk_i),
    .preset_i   (preset_i),
    .flush_i    (flush_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .rd_en_i    (rd_en_i),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .count_o    (count_o),
    .status_o   (status_o)
  );

  initial pclk_i = 1'b0;
  always #5 pclk_i = ~pclk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_status();
    int n;
    logic [7:0] s;
    n    = model_q.size();
    s    = 8'h00;
    s[0] = (n == 0);
    s[1] = (n == 16);
    s[2] = (n <= 1);
    s[3] = (n >= 14);
`ifdef I2C_TX_FIFO_ERR_FLAG_EN
    s[4] = exp_ovf;
    s[5] = exp_udf;
`endif
    return s;
  endfunction

  // One clock of stimulus; the model follows the FIFO rules, then all outputs are compared.
  task automatic step(input bit rst, input bit fl, input bit wr, input logic [7:0] wd, input bit rd);
    int n;
    bit popped;
    @(negedge pclk_i);
    preset_i  = rst;
    flush_i   = fl;
    wr_en_i   = wr;
    wr_data_i = wd;
    rd_en_i   = rd;
    @(posedge pclk_i);
    n = model_q.size();
    if (rst) begin
      model_q.delete();
      exp_data  = 8'h00;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
    end else if (fl) begin
      model_q.delete();
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
    end else begin
      popped = rd && (n > 0);
      if (popped) exp_data = model_q.pop_front();
      exp_valid = popped;
      if (wr && (n < 16 || popped)) model_q.push_back(wd);
      if (wr && n == 16 && !rd) exp_ovf = 1'b1;
      if (rd && n == 0) exp_udf = 1'b1;
    end
    #1;
    $display("txn rst=%0b fl=%0b wr=%0b wd=%02h rd=%0b | cnt=%0d st=%02h vld=%0b dat=%02h",
             rst, fl, wr, wd, rd, count_o, status_o, rd_valid_o, rd_data_o);
    chk("count", count_o, model_q.size());
    chk("status", status_o, model_status());
    chk("rd_valid", rd_valid_o, exp_valid);
    chk("rd_data", rd_data_o, exp_data);
  endtask

  initial begin
    logic [7:0] seq [3];
    logic [7:0] st_full;
    logic [7:0] st_udf;
    int r;

    preset_i = 1'b0; flush_i = 1'b0; wr_en_i = 1'b0; wr_data_i = 8'h00; rd_en_i = 1'b0;
    exp_data = 8'h00; exp_valid = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;

`ifdef I2C_TX_FIFO_ERR_FLAG_EN
    st_full = 8'h1A;
    st_udf  = 8'h20;
`else
    st_full = 8'h0A;
    st_udf  = 8'h00;
`endif

    // reset then idle
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    chk("rst_status", status_o, 8'h05);
    chk("rst_count", count_o, 0);
    chk("rst_valid", rd_valid_o, 0);

    // three writes then three pops in order
    seq[0] = 8'hA1; seq[1] = 8'hB2; seq[2] = 8'hC3;
    for (int i = 0; i < 3; i++) step(0, 0, 1, seq[i], 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 8'h00, 1);
      chk("pop3_data", rd_data_o, seq[i]);
      chk("pop3_valid", rd_valid_o, 1);
    end
    step(0, 0, 0, 8'h00, 0);
    chk("pop3_status", status_o, 8'h05);
    chk("hold_data", rd_data_o, 8'hC3);

    // 17 writes: last one overflows
    for (int i = 0; i <= 16; i++) step(0, 0, 1, 8'(i), 0);
    chk("full_count", count_o, 16);
    chk("full_status", status_o, st_full);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 8'h00, 1);
      chk("drain_data", rd_data_o, 8'(i));
    end
    chk("drain_count", count_o, 0);

    // full FIFO with simultaneous write and pop
    for (int i = 0; i < 16; i++) step(0, 0, 1, 8'($urandom_range(0, 255)), 0);
    step(0, 0, 1, 8'h55, 1);
    chk("fullrw_count", count_o, 16);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 8'h00, 1);
    chk("fullrw_last", rd_data_o, 8'h55);

    // empty FIFO with simultaneous write and pop
    step(0, 0, 1, 8'h7E, 1);
    chk("emptyrw_valid", rd_valid_o, 0);
    chk("emptyrw_count", count_o, 1);
    chk("emptyrw_udf", status_o & 8'h20, st_udf);
    step(0, 0, 0, 8'h00, 1);
    chk("emptyrw_pop", rd_data_o, 8'h7E);

    // flush overrides a concurrent write
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'h30 + i), 0);
    chk("preflush_count", count_o, 5);
    step(0, 1, 1, 8'hEE, 0);
    chk("flush_count", count_o, 0);
    chk("flush_status", status_o, 8'h05);
    step(0, 0, 0, 8'h00, 1);
    chk("flush_nopop", rd_valid_o, 0);

    // random traffic, occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      step((r == 0), (r == 1 || r == 2), ($urandom_range(0, 99) < 55),
           8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 45));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
